arith_unit_seq: RTL and testbench
=================================

// Module: arith_unit_seq
// PURPOSE
//  Parametrised, handshaked arithmetic unit: add, sub, mul, div, mod and optional pow on
//  unsigned WIDTH-bit operands. Single-cycle ops at full throughput; div/mod via iterative restoring divider,
//  pow via iterative square-and-multiply. Shared datapath block for higher-level control logic.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=2); result port is 2*WIDTH bits
// PORTS
//  i_clk     in   1        clock; all logic on rising edge
//  i_rst     in   1        synchronous reset, active-high
//  i_valid   in   1        request valid; i_op/i_a/i_b sampled when i_valid & o_ready
//  o_ready   out  1        unit can accept a request this cycle
//  i_op      in   3        0 add,1 sub,2 mul,3 div,4 mod,5 pow,6-7 illegal
//  i_a       in   WIDTH    operand A (unsigned)
//  i_b       in   WIDTH    operand B (unsigned)
//  o_valid   out  1        one-cycle pulse: o_result/o_rem/o_err valid
//  o_result  out  2*WIDTH  result, zero-extended
//  o_rem     out  WIDTH    remainder (div and mod only, else 0)
//  o_err     out  1        div/mod by zero, pow overflow, or illegal op
// BEHAVIOUR
//  Reset: state IDLE, o_ready=1, o_valid=0, o_result=0, o_rem=0, o_err=0; in-flight op discarded, no o_valid.
//  FSM: IDLE (o_ready=1) -> DIV (div/mod, b!=0) | POW (pow) -> IDLE. Other ops stay in IDLE.
//  Accept at cycle N:
//   add: o_result = a+b (WIDTH+1 bits, carry kept); o_valid at N+1.
//   sub: o_result = (a-b) mod 2^WIDTH, upper bits 0; o_valid at N+1.
//   mul: o_result = a*b, full 2*WIDTH bits; o_valid at N+1.
//   div/mod, b!=0: WIDTH iterations in DIV, one quotient bit/cycle, MSB first; o_valid at N+WIDTH+1.
//     div: o_result=quotient, o_rem=remainder. mod: o_result=remainder, o_rem=remainder.
//   div/mod, b==0: short-circuit, o_valid at N+1, o_err=1; o_result = all-ones WIDTH (div) or a (mod), o_rem=a.
//   pow: WIDTH iterations in POW, scanning b LSB first; o_valid at N+WIDTH+1.
//     o_result = a**b mod 2^(2*WIDTH); a**0 = 1 incl. 0**0. o_err=1 iff true a**b >= 2^(2*WIDTH).
//     Overflow detection: sticky base-overflow flag on squaring; err if a multiply uses an overflowed
//     base or its own product exceeds 2*WIDTH bits. a in {0,1} never flags.
//   illegal op: o_valid at N+1, o_err=1, o_result=0, o_rem=0.
//  Handshake: o_ready=0 from the cycle after an accept of a DIV/POW op until the o_valid cycle;
//   o_ready=1 in that o_valid cycle, so back-to-back accept is legal. i_valid while o_ready=0 is ignored.
//  Single-cycle ops: throughput 1/cycle, o_ready held 1.
//  No output backpressure: o_valid is a single-cycle pulse. o_result/o_rem/o_err hold until the next
//   o_valid; o_err is cleared on every o_valid without error.
//  Operands latched at accept; changes on i_a/i_b during DIV/POW have no effect.
// CONFIGURATION
//  ARITH_POW_EN defined: op 5 = pow as above (extra multiplier + POW state).
//  ARITH_POW_EN undefined: no pow hardware; op 5 treated as illegal (o_valid at N+1, o_err=1, o_result=0).
// TESTING (WIDTH=8 unless noted)
//  add a=7,b=3 then a=255,b=255 back-to-back -> o_result=10 at N+1, 510 at N+2; o_ready stays 1.
//  sub a=3,b=7 -> o_result=252; mul a=255,b=255 -> o_result=65025; op 7 -> o_err=1, o_result=0.
//  div a=19,b=4 -> o_valid at N+9, o_result=4, o_rem=3; o_ready low N+1..N+8; mod same operands -> o_result=3.
//  div a=10,b=0 -> o_valid at N+1, o_err=1, o_result=255, o_rem=10; mod a=10,b=0 -> o_result=10, o_err=1.
//  pow (ARITH_POW_EN) a=3,b=4 -> 81, err=0; a=2,b=16 -> 0, err=1; a=0,b=0 -> 1; a=1,b=255 -> 1, err=0.
//  i_rst=1 at N+4 of div a=200,b=7 -> no o_valid; next cycle all outputs 0, o_ready=1; new add accepted ok.

Source files
------------

// File: rtl/arith_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : arith_unit_seq
// Purpose  : Handshaked unsigned arithmetic unit (add/sub/mul in one cycle,
//            div/mod via restoring divider, optional pow via
//            square-and-multiply). Define ARITH_POW_EN to build the pow path.
// Revision : 1.0  initial release
// ============================================================================
module arith_unit_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [2:0]           i_op,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_valid,
    output logic [2*WIDTH-1:0]   o_result,
    output logic [WIDTH-1:0]     o_rem,
    output logic                 o_err
);

    localparam int           c_CNT_W = $clog2(WIDTH);
    localparam [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_DIV  = 2'd1;
`ifdef ARITH_POW_EN
    localparam logic [1:0] c_S_POW  = 2'd2;
`endif

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_MUL = 3'd2;
    localparam logic [2:0] c_OP_DIV = 3'd3;
    localparam logic [2:0] c_OP_MOD = 3'd4;
`ifdef ARITH_POW_EN
    localparam logic [2:0] c_OP_POW = 3'd5;
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_accept;
    logic               w_last;

    // divider state: partial remainder, dividend/quotient shift register, divisor
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_is_mod;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;

    logic [WIDTH:0]     w_add;
    logic [WIDTH-1:0]   w_sub;
    logic [2*WIDTH-1:0] w_mul;

    assign o_ready  = (r_state == c_S_IDLE);
    assign w_accept = i_valid & o_ready;
    assign w_last   = (r_cnt == c_LAST);

    assign w_add = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub = i_a - i_b;
    assign w_mul = i_a * i_b;

    // Remainder is always below the divisor, so the subtraction fits WIDTH bits.
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_dvs});
    assign w_rem_nxt   = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_dvs) : w_div_shift[WIDTH-1:0];
    assign w_quo_nxt   = {r_quo[WIDTH-2:0], w_div_ge};

`ifdef ARITH_POW_EN
    // pow state: accumulator, running base (a^(2^k)), remaining exponent bits
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_base;
    logic [WIDTH-1:0]   r_exp;
    logic               r_bovf;
    logic               r_perr;
    logic [4*WIDTH-1:0] w_pow_mul;
    logic [4*WIDTH-1:0] w_pow_sq;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_perr_nxt;
    logic               w_bovf_nxt;

    assign w_pow_mul  = r_acc * r_base;
    assign w_pow_sq   = r_base * r_base;
    assign w_acc_nxt  = r_exp[0] ? w_pow_mul[2*WIDTH-1:0] : r_acc;
    // A multiply overflows if its base already overflowed or its own product does.
    assign w_perr_nxt = r_perr | (r_exp[0] & (r_bovf | (|w_pow_mul[4*WIDTH-1:2*WIDTH])));
    assign w_bovf_nxt = r_bovf | (|w_pow_sq[4*WIDTH-1:2*WIDTH]);
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= c_S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: only div/mod with non-zero divisor and pow leave IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    if (((i_op == c_OP_DIV) || (i_op == c_OP_MOD)) && (i_b != '0))
                        w_state_nxt = c_S_DIV;
`ifdef ARITH_POW_EN
                    else if (i_op == c_OP_POW)
                        w_state_nxt = c_S_POW;
`endif
                end
            end
            c_S_DIV: if (w_last) w_state_nxt = c_S_IDLE;
`ifdef ARITH_POW_EN
            c_S_POW: if (w_last) w_state_nxt = c_S_IDLE;
`endif
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_result <= '0;
            o_rem    <= '0;
            o_err    <= 1'b0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_is_mod <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        case (i_op)
                            c_OP_ADD: begin
                                o_valid  <= 1'b1;
                                o_result <= {{(WIDTH-1){1'b0}}, w_add};
                                o_rem    <= '0;
                                o_err    <= 1'b0;
                            end
                            c_OP_SUB: begin
                                o_valid  <= 1'b1;
                                o_result <= {{WIDTH{1'b0}}, w_sub};
                                o_rem    <= '0;
                                o_err    <= 1'b0;
                            end
                            c_OP_MUL: begin
                                o_valid  <= 1'b1;
                                o_result <= w_mul;
                                o_rem    <= '0;
                                o_err    <= 1'b0;
                            end
                            c_OP_DIV, c_OP_MOD: begin
                                if (i_b == '0) begin
                                    o_valid  <= 1'b1;
                                    o_err    <= 1'b1;
                                    o_rem    <= i_a;
                                    o_result <= (i_op == c_OP_DIV) ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                                                   : {{WIDTH{1'b0}}, i_a};
                                end else begin
                                    r_rem    <= '0;
                                    r_quo    <= i_a;
                                    r_dvs    <= i_b;
                                    r_is_mod <= (i_op == c_OP_MOD);
                                end
                            end
`ifdef ARITH_POW_EN
                            c_OP_POW: ;
`endif
                            default: begin
                                o_valid  <= 1'b1;
                                o_err    <= 1'b1;
                                o_result <= '0;
                                o_rem    <= '0;
                            end
                        endcase
                    end
                end
                c_S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        o_valid  <= 1'b1;
                        o_err    <= 1'b0;
                        o_rem    <= w_rem_nxt;
                        o_result <= r_is_mod ? {{WIDTH{1'b0}}, w_rem_nxt}
                                             : {{WIDTH{1'b0}}, w_quo_nxt};
                    end
                end
`ifdef ARITH_POW_EN
                c_S_POW: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        o_valid  <= 1'b1;
                        o_err    <= w_perr_nxt;
                        o_rem    <= '0;
                        o_result <= w_acc_nxt;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef ARITH_POW_EN
    // Square-and-multiply iteration, exponent scanned LSB first
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc  <= '0;
            r_base <= '0;
            r_exp  <= '0;
            r_bovf <= 1'b0;
            r_perr <= 1'b0;
        end else if (w_accept && (i_op == c_OP_POW)) begin
            r_acc  <= {{(2*WIDTH-1){1'b0}}, 1'b1};
            r_base <= {{WIDTH{1'b0}}, i_a};
            r_exp  <= i_b;
            r_bovf <= 1'b0;
            r_perr <= 1'b0;
        end else if (r_state == c_S_POW) begin
            r_acc  <= w_acc_nxt;
            r_base <= w_pow_sq[2*WIDTH-1:0];
            r_exp  <= r_exp >> 1;
            r_bovf <= w_bovf_nxt;
            r_perr <= w_perr_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_arith_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_unit_seq
// Purpose  : Directed self-checking bench for arith_unit_seq (WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_arith_unit_seq;

    localparam int WIDTH = 8;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 ready;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     rem;
    logic                 err;

    int n_checks;
    int n_errors;

    arith_unit_seq #(.WIDTH(WIDTH)) u_dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid),
        .o_ready (ready),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .o_valid (out_valid),
        .o_result(result),
        .o_rem   (rem),
        .o_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one cycle; returns in cycle N+1
    task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        tick();
        in_valid = 1'b0;
    endtask

    // Multi-cycle request: o_ready low and no o_valid for N+1..N+8, then o_valid at N+9.
    // Junk requests with changing operands are presented while busy.
    task automatic issue_multi(input string tag, input logic [2:0] o,
                               input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int bad;
        bad = 0;
        issue(o, x, y);
        for (int k = 1; k <= WIDTH; k++) begin
            if (ready !== 1'b0 || out_valid !== 1'b0) bad++;
            in_valid = (k < WIDTH);
            op = 3'd0;
            a  = WIDTH'($urandom);
            b  = WIDTH'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check_eq({tag, "_busy"}, bad, 0);
        check_eq({tag, "_valid"}, out_valid, 1);
        check_eq({tag, "_ready"}, ready, 1);
    endtask

    initial begin
        int bad;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        tick();
        tick();
        check_eq("rst_ready", ready, 1);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_rem", rem, 0);
        check_eq("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // back-to-back adds
        in_valid = 1'b1; op = 3'd0; a = 8'd7; b = 8'd3;
        tick();
        check_eq("add1_valid", out_valid, 1);
        check_eq("add1_result", result, 10);
        check_eq("add1_ready", ready, 1);
        a = 8'd255; b = 8'd255;
        tick();
        in_valid = 1'b0;
        check_eq("add2_valid", out_valid, 1);
        check_eq("add2_result", result, 510);
        check_eq("add2_ready", ready, 1);
        tick();
        check_eq("add_pulse", out_valid, 0);
        check_eq("add_hold", result, 510);

        issue(3'd1, 8'd3, 8'd7);
        check_eq("sub_result", result, 252);
        check_eq("sub_err", err, 0);

        issue(3'd2, 8'd255, 8'd255);
        check_eq("mul_result", result, 65025);
        check_eq("mul_rem", rem, 0);

        issue(3'd7, 8'd9, 8'd9);
        check_eq("ill_valid", out_valid, 1);
        check_eq("ill_err", err, 1);
        check_eq("ill_result", result, 0);

        issue(3'd0, 8'd1, 8'd1);
        check_eq("err_clear", err, 0);
        check_eq("err_clear_res", result, 2);

        issue_multi("div", 3'd3, 8'd19, 8'd4);
        check_eq("div_result", result, 4);
        check_eq("div_rem", rem, 3);
        check_eq("div_err", err, 0);

        issue_multi("mod", 3'd4, 8'd19, 8'd4);
        check_eq("mod_result", result, 3);
        check_eq("mod_rem", rem, 3);
        // accept in the o_valid cycle
        issue(3'd0, 8'd2, 8'd3);
        check_eq("b2b_valid", out_valid, 1);
        check_eq("b2b_result", result, 5);

        issue_multi("div2", 3'd3, 8'd200, 8'd7);
        check_eq("div2_result", result, 28);
        check_eq("div2_rem", rem, 4);

        issue(3'd3, 8'd10, 8'd0);
        check_eq("div0_valid", out_valid, 1);
        check_eq("div0_err", err, 1);
        check_eq("div0_result", result, 255);
        check_eq("div0_rem", rem, 10);
        check_eq("div0_ready", ready, 1);

        issue(3'd4, 8'd10, 8'd0);
        check_eq("mod0_valid", out_valid, 1);
        check_eq("mod0_err", err, 1);
        check_eq("mod0_result", result, 10);

`ifdef ARITH_POW_EN
        issue_multi("pow1", 3'd5, 8'd3, 8'd4);
        check_eq("pow1_result", result, 81);
        check_eq("pow1_err", err, 0);
        issue_multi("pow2", 3'd5, 8'd2, 8'd16);
        check_eq("pow2_result", result, 0);
        check_eq("pow2_err", err, 1);
        issue_multi("pow3", 3'd5, 8'd0, 8'd0);
        check_eq("pow3_result", result, 1);
        check_eq("pow3_err", err, 0);
        issue_multi("pow4", 3'd5, 8'd1, 8'd255);
        check_eq("pow4_result", result, 1);
        check_eq("pow4_err", err, 0);
        issue_multi("pow5", 3'd5, 8'd2, 8'd15);
        check_eq("pow5_result", result, 32768);
        check_eq("pow5_err", err, 0);
`else
        issue(3'd5, 8'd3, 8'd4);
        check_eq("pow_ill_valid", out_valid, 1);
        check_eq("pow_ill_err", err, 1);
        check_eq("pow_ill_result", result, 0);
        check_eq("pow_ill_ready", ready, 1);
`endif

        // reset while dividing: accept at N, reset asserted during N+4
        issue(3'd3, 8'd200, 8'd7);
        bad = 0;
        for (int k = 1; k <= 3; k++) begin
            if (out_valid !== 1'b0 || ready !== 1'b0) bad++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstdiv_busy", bad, 0);
        check_eq("rstdiv_valid", out_valid, 0);
        check_eq("rstdiv_result", result, 0);
        check_eq("rstdiv_rem", rem, 0);
        check_eq("rstdiv_err", err, 0);
        check_eq("rstdiv_ready", ready, 1);
        bad = 0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            if (out_valid !== 1'b0) bad++;
            tick();
        end
        check_eq("rstdiv_novalid", bad, 0);
        issue(3'd0, 8'd100, 8'd50);
        check_eq("post_rst_valid", out_valid, 1);
        check_eq("post_rst_result", result, 150);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
